// File: rtl/mux_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter_pkg
// Shared definitions for the mux-sharing arbiter: requester count, FSM state
// encoding and a small one-hot helper.
// -----------------------------------------------------------------------------
package mux_share_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot vector with bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter_if
// Bundle between the four requesters and the arbiter.
//   req   : per-requester level request (bit i = mux input i)
//   grant : one-hot grant, zero when the mux is unowned
//   sel   : 2-bit select for the shared 4:1 mux
//   busy  : arbiter is in a grant or guard-gap period
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mux_share_arbiter_if;

  logic [mux_share_arbiter_pkg::N_REQ-1:0] req;
  logic [mux_share_arbiter_pkg::N_REQ-1:0] grant;
  logic [1:0]                              sel;
  logic                                    busy;

  modport master (output req, input grant, sel, busy);
  modport slave  (input req, output grant, sel, busy);

endinterface

// File: rtl/mux_share_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters. Searches in the order
// last+1, last+2, last+3, last (mod 4) and returns the first set request.
//   req_i    : request vector
//   last_i   : index of the most recent owner
//   winner_o : chosen index (equals last_i when nothing is requested)
//   found_o  : at least one request was set
// -----------------------------------------------------------------------------
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] winner_o,
  output logic       found_o
);

  logic [1:0] cand;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    winner_o = last_i;
    found_o  = 1'b0;
    cand     = last_i;
    // k = 4 wraps to last_i itself, so the previous owner is searched last.
    for (int k = 1; k <= 4; k++) begin
      cand = last_i + 2'(k);
      if (!found_o && req_i[cand]) begin
        winner_o = cand;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter
// Round-robin owner of a shared 4:1 signal mux. Grants are held while the
// owner's request stays high, cut after MAX_HOLD cycles if someone else is
// waiting, and separated by GAP_CYCLES idle guard cycles.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of mux_share_arbiter_if (req in; grant/sel/busy out)
// Parameters:
//   MAX_HOLD   (1..255) : contended grant length limit in cycles
//   GAP_CYCLES (1..15)  : guard cycles between consecutive owners
// -----------------------------------------------------------------------------
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_share_arbiter_if.slave  bus
);

  localparam int unsigned    CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         last_q,  last_d;
  logic [CNT_W-1:0]   hold_q,  hold_d;
  logic [3:0]         gap_q,   gap_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [1:0]         sel_q,   sel_d;
  logic               busy_q,  busy_d;

  logic [1:0]         winner;
  logic               found;
  logic               others_waiting;
  logic               owner_done;

  rr_pick4 u_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // While granted, sel_q is the owner index.
  assign others_waiting = |(bus.req & ~onehot(sel_q));
  // Release takes precedence over preempt, but both lead to the same GAP.
  assign owner_done     = !bus.req[sel_q] ||
                          (hold_q == HOLD_LAST && others_waiting);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = onehot(winner);
          sel_d   = winner;
          last_d  = winner;
          hold_d  = '0;
          busy_d  = 1'b1;
        end
      end

      GRANT: begin
        if (owner_done) begin
          state_d = GAP;
          grant_d = '0;
          gap_d   = '0;
        end else if (hold_q != HOLD_LAST) begin
          // Saturates at MAX_HOLD-1: an uncontended owner keeps the mux.
          hold_d = hold_q + 1'b1;
        end
      end

      GAP: begin
        // Requests are only looked at on the last gap cycle; sel is untouched.
        if (gap_q == GAP_LAST) begin
          if (found) begin
            state_d = GRANT;
            grant_d = onehot(winner);
            sel_d   = winner;
            last_d  = winner;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 2'd3;   // requester 0 is searched first after reset
      hold_q  <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_share_arbiter
// Two arbiter instances (A: MAX_HOLD=4, GAP_CYCLES=1; B: MAX_HOLD=16,
// GAP_CYCLES=3) compared every cycle against a behavioural model, plus
// directed scenarios with closed-form expectations.
// -----------------------------------------------------------------------------
module tb_mux_share_arbiter;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 16;
  localparam int GAP_B  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_share_arbiter_if bus_a ();
  mux_share_arbiter_if bus_b ();

  mux_share_arbiter #(.MAX_HOLD(HOLD_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mux_share_arbiter #(.MAX_HOLD(HOLD_B), .GAP_CYCLES(GAP_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Behavioural model, one entry per instance: owner index (-1 = none),
  // cycles granted so far, gap cycles remaining, last owner, select value.
  int m_owner [2];
  int m_held  [2];
  int m_gap   [2];
  int m_last  [2];
  int m_sel   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic int max_hold(input int id);
    return (id == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int gap_len(input int id);
    return (id == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic model_reset(input int id);
    m_owner[id] = -1;
    m_held[id]  = 0;
    m_gap[id]   = 0;
    m_last[id]  = 3;
    m_sel[id]   = 0;
  endtask

  task automatic model_grant(input int id, input logic [3:0] r);
    bit done = 0;
    for (int k = 1; k <= 4; k++) begin
      int c = (m_last[id] + k) % 4;
      if (!done && r[c]) begin
        done        = 1;
        m_owner[id] = c;
        m_last[id]  = c;
        m_sel[id]   = c;
        m_held[id]  = 0;
      end
    end
  endtask

  task automatic model_step(input int id, input logic [3:0] r);
    if (m_owner[id] >= 0) begin
      logic [3:0] mine;
      bit         others;
      m_held[id] = m_held[id] + 1;
      mine   = 4'b0001 << m_owner[id];
      others = (r & ~mine) != 4'b0000;
      if (!r[m_owner[id]] || (m_held[id] >= max_hold(id) && others)) begin
        m_owner[id] = -1;
        m_gap[id]   = gap_len(id);
      end
    end else if (m_gap[id] > 0) begin
      m_gap[id] = m_gap[id] - 1;
      if (m_gap[id] == 0 && r != 4'b0000) model_grant(id, r);
    end else if (r != 4'b0000) begin
      model_grant(id, r);
    end
  endtask

  function automatic logic [3:0] exp_grant(input int id);
    return (m_owner[id] < 0) ? 4'b0000 : 4'(4'b0001 << m_owner[id]);
  endfunction

  function automatic logic [3:0] exp_busy(input int id);
    return (m_owner[id] >= 0 || m_gap[id] > 0) ? 4'd1 : 4'd0;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("a.grant", bus_a.grant,          exp_grant(0));
    check("a.sel",   {2'b00, bus_a.sel},   4'(m_sel[0]));
    check("a.busy",  {3'b000, bus_a.busy}, exp_busy(0));
    check("b.grant", bus_b.grant,          exp_grant(1));
    check("b.sel",   {2'b00, bus_b.sel},   4'(m_sel[1]));
    check("b.busy",  {3'b000, bus_b.busy}, exp_busy(1));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // sample 1 time unit after the edge.
  task automatic step(input logic [3:0] ra, input logic [3:0] rb, input logic r);
    bus_a.req = ra;
    bus_b.req = rb;
    rst       = r;
    @(posedge clk);
    if (r) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, ra);
      model_step(1, rb);
    end
    #1;
    check_model();
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rr;

    bus_a.req = '0;
    bus_b.req = '0;
    rst       = 1'b1;
    model_reset(0);
    model_reset(1);

    // Reset values.
    step(4'h0, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    check("rst.a.grant", bus_a.grant, 4'b0000);
    check("rst.b.sel",   {2'b00, bus_b.sel}, 4'd0);

    // Single request on B, then release; busy clears after GAP_B cycles.
    step(4'h0, 4'b0100, 1'b0);
    check("t1.grant", bus_b.grant, 4'b0100);
    check("t1.sel",   {2'b00, bus_b.sel}, 4'd2);
    check("t1.busy",  {3'b000, bus_b.busy}, 4'd1);
    repeat (3) step(4'h0, 4'b0100, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    check("t1.rel.grant", bus_b.grant, 4'b0000);
    check("t1.rel.sel",   {2'b00, bus_b.sel}, 4'd2);
    repeat (GAP_B - 1) step(4'h0, 4'h0, 1'b0);
    check("t1.gap.busy",  {3'b000, bus_b.busy}, 4'd1);
    step(4'h0, 4'h0, 1'b0);
    check("t1.idle.busy", {3'b000, bus_b.busy}, 4'd0);

    // Full contention on A: 4-cycle grants rotating 0,1,2,3,0 with 1-cycle gaps.
    for (int t = 0; t < 25; t++) begin
      step(4'hF, 4'h0, 1'b0);
      check("t2.grant", bus_a.grant,
            ((t % 5) < 4) ? 4'(4'b0001 << ((t / 5) % 4)) : 4'b0000);
      check("t2.sel", {2'b00, bus_a.sel}, 4'((t / 5) % 4));
    end
    repeat (2) step(4'h0, 4'h0, 1'b0);

    // Lone requester on B keeps the mux past MAX_HOLD.
    for (int t = 0; t < 40; t++) begin
      step(4'h0, 4'b0001, 1'b0);
      check("t3.grant", bus_b.grant, 4'b0001);
    end
    repeat (GAP_B + 2) step(4'h0, 4'h0, 1'b0);

    // Owner 2 on B, requester 3 arrives while the hold counter is 5.
    for (int t = 1; t <= HOLD_B; t++) begin
      step(4'h0, (t <= 6) ? 4'b0100 : 4'b1100, 1'b0);
      check("t4.hold", bus_b.grant, 4'b0100);
    end
    step(4'h0, 4'b1100, 1'b0);
    check("t4.preempt", bus_b.grant, 4'b0000);
    repeat (GAP_B - 1) begin
      step(4'h0, 4'b1100, 1'b0);
      check("t4.gap", bus_b.grant, 4'b0000);
    end
    step(4'h0, 4'b1100, 1'b0);
    check("t4.next.grant", bus_b.grant, 4'b1000);
    check("t4.next.sel",   {2'b00, bus_b.sel}, 4'd3);
    repeat (GAP_B + 2) step(4'h0, 4'h0, 1'b0);

    // Release on A coinciding with the preempt point, requester 1 pending.
    step(4'b0001, 4'h0, 1'b0);
    repeat (HOLD_A - 1) step(4'b0011, 4'h0, 1'b0);
    check("t5.last", bus_a.grant, 4'b0001);
    step(4'b0010, 4'h0, 1'b0);
    check("t5.gap",  bus_a.grant, 4'b0000);
    check("t5.busy", {3'b000, bus_a.busy}, 4'd1);
    step(4'b0010, 4'h0, 1'b0);
    check("t5.next", bus_a.grant, 4'b0010);
    repeat (3) step(4'h0, 4'h0, 1'b0);

    // Reset mid-grant to requester 3, then requester 0 wins over 3.
    repeat (3) step(4'b1000, 4'h0, 1'b0);
    check("t6.owner", bus_a.grant, 4'b1000);
    step(4'b1000, 4'h0, 1'b1);
    check("t6.rst.grant", bus_a.grant, 4'b0000);
    check("t6.rst.sel",   {2'b00, bus_a.sel}, 4'd0);
    check("t6.rst.busy",  {3'b000, bus_a.busy}, 4'd0);
    step(4'b1001, 4'h0, 1'b0);
    check("t6.first", bus_a.grant, 4'b0001);
    repeat (3) step(4'h0, 4'h0, 1'b0);

    // Randomised sticky requests with rare resets.
    ra = 4'h0;
    rb = 4'h0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      end
      rr = ($urandom_range(0, 499) == 0);
      step(ra, rb, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
